// File: rtl/csum_pkg.sv
// Shared types and helpers for the streaming one's-complement checksum.
package csum_pkg;

  localparam int unsigned SUM_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned KEEP_MAX   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } csum_state_t;

  // Each keep bit expands to a byte mask; keep[i] covers data[i*8 +: 8].
  function automatic logic [8*KEEP_MAX-1:0] keep_mask(input logic [KEEP_MAX-1:0] keep);
    logic [8*KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      m[i*8 +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/csum_fold.sv
// Combinational end-around-carry reducer: folds an IN_W-bit sum into SUM_W bits.
module csum_fold #(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned SUM_W = 16
) (
  input  logic [IN_W-1:0]  sum_i,
  output logic [SUM_W-1:0] fold_o
);

  logic [SUM_W:0] pass1;
  logic [SUM_W:0] pass2;

  // The second pass absorbs at most a single carry out of the first.
  always_comb begin
    pass1  = {1'b0, sum_i[SUM_W-1:0]} + (SUM_W+1)'(sum_i[IN_W-1:SUM_W]);
    pass2  = {1'b0, pass1[SUM_W-1:0]} + (SUM_W+1)'(pass1[SUM_W]);
    fold_o = pass2[SUM_W-1:0];
  end

endmodule

// File: rtl/csum_stream.sv
// Streaming RFC 1071 checksum: masks, lane-adds and folds one beat per cycle,
// emitting the complemented sum one cycle after the last beat.
module csum_stream
  import csum_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SUM_W    = SUM_W_DEF,
  parameter int unsigned KEEP_W   = DATA_W / 8,
  parameter bit          UDP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SUM_W-1:0]  init_i,
  output logic              cs_valid_o,
  output logic [SUM_W-1:0]  cs_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned LANES = DATA_W / SUM_W;
  localparam int unsigned ADD_W = SUM_W + $clog2(LANES + 1);

  csum_state_t       state;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  base;
  logic [SUM_W-1:0]  folded;
  logic [SUM_W-1:0]  result;
  logic [SUM_W-1:0]  cs_next;
  logic [KEEP_W-1:0] keep_eff;
  logic [DATA_W-1:0] masked;
  logic [ADD_W-1:0]  beat_sum;

  // A start beat always reseeds from init_i, including a mid-packet restart.
  always_comb begin
    keep_eff = last_i ? keep_i : '1;
    masked   = data_i & DATA_W'(keep_mask(KEEP_MAX'(keep_eff)));
    base     = (state == IDLE || start_i) ? init_i : acc;
    beat_sum = ADD_W'(base);
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + ADD_W'(masked[i*SUM_W +: SUM_W]);
    end
    result  = ~folded;
    cs_next = (UDP_ZERO && result == '0) ? '1 : result;
  end

  csum_fold #(
    .IN_W  (ADD_W),
    .SUM_W (SUM_W)
  ) u_fold (
    .sum_i  (beat_sum),
    .fold_o (folded)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      acc        <= '0;
      cs_o       <= '0;
      cs_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      cs_valid_o <= 1'b0;
      err_o      <= 1'b0;
      if (valid_i) begin
        if (start_i) begin
          if (state == ACC) err_o <= 1'b1;
          acc <= folded;
          if (last_i) begin
            cs_o       <= cs_next;
            cs_valid_o <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= ACC;
          end
        end else if (state == IDLE) begin
          err_o <= 1'b1;
        end else begin
          acc <= folded;
          if (last_i) begin
            cs_o       <= cs_next;
            cs_valid_o <= 1'b1;
            state      <= IDLE;
          end
        end
      end
    end
  end

  assign busy_o = (state == ACC);

endmodule

// File: doc/csum_stream.md
# csum_stream

Streaming 16-bit one's-complement checksum accumulator (RFC 1071) for the IPv4/UDP datapath. It consumes a packet as a sequence of `DATA_W`-bit beats and folds each beat into a running sum with end-around carry. It applies byte-enable masking for the final partial beat and emits the complemented checksum one cycle after the last beat. It sits between the MAC/IP beat parser and the header insertion stage, and can be seeded with a partial pseudo-header sum.

## Interface
- `DATA_W`, 32: beat width. Must be a multiple of `SUM_W`.
- `SUM_W`, 16: checksum width.
- `KEEP_W`, `DATA_W/8`: byte-enable width.
- `UDP_ZERO`, 1: when 1, a computed checksum of `16'h0000` is output as `16'hFFFF`.

Ports:
- `clk`  in  1: single clock.
- `nreset`  in  1: reset, asynchronous, active-low.
- `valid_i`  in  1: beat valid.
- `start_i`  in  1: first beat of packet. Qualified by `valid_i`.
- `last_i`  in  1: last beat of packet. Qualified by `valid_i`.
- `keep_i`  in  `KEEP_W`: byte enables. MSB is the first byte on the wire (`data_i[DATA_W-1 -: 8]`).
- `data_i`  in  `DATA_W`: beat data, big-endian.
- `init_i`  in  `SUM_W`: seed sum. Sampled on the start beat.
- `cs_valid_o`  out  1: one-cycle pulse, checksum ready.
- `cs_o`  out  `SUM_W`: complemented checksum. Held until the next `cs_valid_o`.
- `busy_o`  out  1: packet in progress (state ACC).
- `err_o`  out  1: one-cycle pulse on a protocol error.

## Operation
- States: IDLE, ACC.
- IDLE:
  - `valid_i & start_i & ~last_i`: set `acc = fold(init_i + beat)`, go to ACC.
  - `valid_i & start_i & last_i`: single-beat packet; compute the result directly, stay in IDLE.
  - `valid_i & ~start_i`: beat ignored, `err_o` pulses.
- ACC:
  - `valid_i & ~start_i`: set `acc = fold(acc + beat)`. On `last_i`, emit the result and go to IDLE.
  - `valid_i & start_i`: abort the current packet, pulse `err_o`, restart with `init_i` using the same rules as IDLE. The aborted packet produces no `cs_valid_o`.
  - `~valid_i`: hold `acc` and state. Bubbles are allowed anywhere in a packet.
- Beat sum:
  - Mask each byte whose `keep_i` bit is 0 to zero. This zero-pads odd-length packets per RFC 1071.
  - Split the masked beat into `DATA_W/SUM_W` lanes and add them.
  - `keep_i` is contiguous from the MSB. It is checked only on the last beat; non-last beats are treated as all-ones regardless of `keep_i`.
- `fold(x)`: end-around carry. Add the bits above `SUM_W` back into the low `SUM_W` bits, repeating until no carry remains; two passes are sufficient for the widths used. `acc` is always `SUM_W` bits.
- Result: `r = ~fold(acc_final)`. If `UDP_ZERO` and `r == 0`, output `16'hFFFF`.
- Reset values: state IDLE, `acc` 0, `cs_o` 0, `cs_valid_o` 0, `busy_o` 0, `err_o` 0.
- Reset asserted mid-packet discards the packet. No output is produced for it.

## Timing
- Last beat accepted at cycle N: `cs_valid_o` is high and `cs_o` is valid in cycle N+1. Latency is fixed at 1.
- No backpressure. A beat is accepted every cycle `valid_i` is high.
- Back-to-back packets are supported: a start beat in cycle N+1 is accepted while the previous result is being presented.
- `err_o` is registered and appears the cycle after the offending beat.
- The combinational path per beat is mask, lane add, fold. It must close at line rate; do not add pipeline stages, because that would change the latency.

## Structure
- `csum_pkg`:
  - `SUM_W` and the default `DATA_W`.
  - State enum `csum_state_t` with values IDLE and ACC.
  - Function `keep_mask` (keep to bit mask).
- Sub-module `csum_fold`: purely combinational end-around-carry reducer. Parameters are input width and `SUM_W`. It is instantiated for the beat-plus-accumulator path.

## Test plan
- IPv4 header, `init_i=0`, 5 beats: `45000073 00004000 40110000 c0a80001 c0a800c7`, `keep` all ones -> `cs_o=16'hB861`, `cs_valid_o` exactly one cycle after the last beat.
- Odd length: single beat with start and last, `data 32'h01020304`, `keep 4'b1110` -> sum `0x0402`, `cs_o=16'hFBFD`.
- Zero mapping: single beat `32'hFFFFFFFF`, keep all ones:
  - `UDP_ZERO=1` -> `cs_o=16'hFFFF`.
  - `UDP_ZERO=0` -> `cs_o=16'h0000`.
- Carry fold with seed: `init_i=16'hFFFF`, single beat `32'h00010000` -> `cs_o=16'hFFFE`.
- Restart: start, one beat, then a new start mid-packet followed by the IPv4 header from the first scenario -> `err_o` pulses once and the only `cs_valid_o` carries `16'hB861`.
- Bubbles and reset: the IPv4 header with `valid_i` low between every beat -> `16'hB861`. Then `nreset` asserted after beat 3 of a repeat -> no `cs_valid_o`, all outputs 0, next packet correct.
